pipeline_output_merger: RTL and testbench
=========================================

Name: pipeline_output_merger

Overview:
- Sits directly downstream of the dual-pipeline wrapper.
- Consumes the two pipelines' outputs and per-lane valids. Buffers each lane in a small FIFO and merges both lanes into one valid/ready stream with round-robin fairness.
- The pipelines have no backpressure, so lane flushes are honoured and overflow is handled locally, with an optional drop count.

Parameters:
- DATA_W, 32, data width per lane and of the merged output.
- DEPTH, 4, entries per lane FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data_1  input  DATA_W  pipeline 1 output data.
- in_data_2  input  DATA_W  pipeline 2 output data.
- in_valid  input  2  bit0 = lane 1 valid, bit1 = lane 2 valid.
- flush_1  input  1  clear lane 1 FIFO.
- flush_2  input  1  clear lane 2 FIFO.
- out_data  output  DATA_W  merged data.
- out_lane  output  1  source lane of out_data (0 = lane 1, 1 = lane 2).
- out_valid  output  1  merged data valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- lane_full  output  2  per-lane FIFO full (count == DEPTH).

Behaviour:
- Reset (async, active-high):
  - Both FIFOs empty; out_valid=0, out_data=0, out_lane=0, lane_full=0.
  - last_served=1 (lane 2), so lane 1 wins the first tie; lock=0; drop counters=0.
- Lane write:
  - Occurs when in_valid[i] && (!full_i || pop_i) && !flush_i. A full FIFO popped in the same cycle accepts the write.
  - Otherwise in_valid[i] data is dropped. Drops caused by full are counted when the macro is enabled; drops caused by flush are never counted.
- Latency: data written at edge k is presented (out_valid=1) in the cycle after edge k if selected. Output is combinational from the selected FIFO head; no extra register.
- Selection:
  - Only one lane non-empty: that lane is selected.
  - Both non-empty: the lane != last_served is selected.
  - Neither non-empty: out_valid=0, out_data=0.
- Stability:
  - While out_valid && !out_ready, lock=1 and the selected lane is frozen until the handshake. A lane becoming non-empty meanwhile must not change out_data or out_lane.
  - Sole exception: a flush of the locked lane.
- Pop: on out_valid && out_ready, the selected FIFO head is removed, last_served <= selected lane, lock <= 0.
- Flush:
  - flush_i clears lane i pointers and count at the next edge. It has priority over any write to lane i in that cycle.
  - A handshake on lane i in the same cycle counts as delivered; the remaining entries are discarded.
  - If the locked lane is flushed, lock clears; next cycle re-selects or drops out_valid.
  - The other lane is unaffected.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; separate count 0..DEPTH. Simultaneous write+pop leaves the count unchanged.
- Reset mid-operation: all state clears immediately; pending data is lost; out_valid falls without waiting for a clock.

Optional Feature:
- Macro: MERGE_DROP_CNT_EN.
- Defined: adds outputs drop_cnt_1 and drop_cnt_2 (16 bits each).
  - Each increments by 1 per cycle in which in_valid[i]=1 is rejected because lane i is full and not popped.
  - Saturates at 0xFFFF; cleared only by reset; flush does not clear it.
- Undefined: ports and counters are absent; drops are silent. All other behaviour is identical.

Test Plan:
- Single lane: DEPTH=4, out_ready=1, lane 1 writes 0xA0,0xA1,0xA2,0xA3 on consecutive cycles → out_data 0xA0..0xA3 in order, each one cycle after its write, out_lane=0, no drops.
- Fairness: out_ready=1, both lanes write simultaneously 0x11/0x22, then 0x33/0x44 → output sequence 0x11(L1),0x22(L2),0x33(L1),0x44(L2).
- Overflow: out_ready=0, lane 1 writes 0x01..0x05 → lane_full[0]=1 after the 4th write; 0x05 dropped, drop_cnt_1=1 (macro on). Raising out_ready drains 0x01..0x04 only.
- Stability: out_ready=0, lane 2 holds 0x55 (presented, out_lane=1); lane 1 then receives 0x66 → out_data stays 0x55 until out_ready=1. Next cycle presents 0x66.
- Flush: lane 1 holds 0x10,0x20,0x30, lane 2 holds 0x99, out_ready=0; pulse flush_1 with in_valid[0]=1 (data 0x40) → next cycle lane 1 empty, 0x40 discarded, out_data=0x99, out_lane=1.
- Async reset: assert reset mid-stream between clock edges with both FIFOs partially full → out_valid=0 and lane_full=0 immediately. After release, the first tie selects lane 1.

Source files
------------

// File: rtl/pipeline_output_merger.sv
// pipeline_output_merger
// Merges the two lanes of the dual-pipeline wrapper into one valid/ready
// stream. Each lane is buffered in a small FIFO. Lanes are served
// round-robin, and the presented lane is held while the consumer stalls.
// The pipelines cannot be back-pressured, so a full lane drops its input.
// Optional feature: define MERGE_DROP_CNT_EN to add saturating per-lane
// drop counters (drop_cnt_1, drop_cnt_2) for overflow drops.
module pipeline_output_merger #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [1:0]        in_valid,
    input  logic              flush_1,
    input  logic              flush_2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        lane_full
`ifdef MERGE_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt_1,
    output logic [15:0]       drop_cnt_2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r    [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r [2];
    logic [PTR_W-1:0]  rd_ptr_r [2];
    logic [CNT_W-1:0]  count_r  [2];
    logic [DATA_W-1:0] wdata_s  [2];

    logic [1:0] flush_s;
    logic [1:0] not_empty_s;
    logic [1:0] full_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic       handshake_s;
    logic       sel_lane_s;
    logic       lock_r;
    logic       lock_lane_r;
    logic       last_served_r;

    assign wdata_s[0] = in_data_1;
    assign wdata_s[1] = in_data_2;
    assign flush_s    = {flush_2, flush_1};
    assign lane_full  = full_s;

    // Per-lane occupancy flags derived from the stored counts.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            not_empty_s[i] = (count_r[i] != CNT_W'(0));
            full_s[i]      = (count_r[i] == CNT_W'(DEPTH));
        end
    end

    // Lane arbitration: a held lane wins, otherwise round-robin on a tie.
    always_comb begin
        sel_lane_s = 1'b0;
        if (lock_r) begin
            sel_lane_s = lock_lane_r;
        end else if (&not_empty_s) begin
            sel_lane_s = ~last_served_r;
        end else if (not_empty_s[1]) begin
            sel_lane_s = 1'b1;
        end else begin
            sel_lane_s = 1'b0;
        end
    end

    // Present the head of the selected FIFO; zero data when nothing is queued.
    always_comb begin
        out_valid = not_empty_s[sel_lane_s];
        out_lane  = sel_lane_s;
        if (out_valid) begin
            out_data = mem_r[sel_lane_s][rd_ptr_r[sel_lane_s]];
        end else begin
            out_data = {DATA_W{1'b0}};
        end
    end

    // Pop/push qualification. A full lane that is popped this cycle still
    // accepts the write, and a flush overrides any write.
    always_comb begin
        handshake_s = out_valid & out_ready;
        pop_s[0]    = handshake_s & ~sel_lane_s;
        pop_s[1]    = handshake_s & sel_lane_s;
        for (int i = 0; i < 2; i++) begin
            push_s[i] = in_valid[i] & (~full_s[i] | pop_s[i]) & ~flush_s[i];
        end
    end

    // FIFO storage writes. The data array needs no reset because the
    // count gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= wdata_s[i];
            end
        end
    end

    // FIFO pointers and counts. A flush discards everything left in the lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_r[i] <= PTR_W'(0);
                rd_ptr_r[i] <= PTR_W'(0);
                count_r[i]  <= CNT_W'(0);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (flush_s[i]) begin
                    wr_ptr_r[i] <= PTR_W'(0);
                    rd_ptr_r[i] <= PTR_W'(0);
                    count_r[i]  <= CNT_W'(0);
                end else begin
                    if (push_s[i]) begin
                        wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                    end
                    if (pop_s[i]) begin
                        rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                    end
                    case ({push_s[i], pop_s[i]})
                        2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
                        2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
                        default: count_r[i] <= count_r[i];
                    endcase
                end
            end
        end
    end

    // Round-robin history and the stall lock. The lock is not taken on a
    // lane that is being flushed, so a flushed lane never stays selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_r        <= 1'b0;
            lock_lane_r   <= 1'b0;
            last_served_r <= 1'b1;
        end else if (handshake_s) begin
            lock_r        <= 1'b0;
            last_served_r <= sel_lane_s;
        end else if (out_valid && !flush_s[sel_lane_s]) begin
            lock_r      <= 1'b1;
            lock_lane_r <= sel_lane_s;
        end else begin
            lock_r <= 1'b0;
        end
    end

`ifdef MERGE_DROP_CNT_EN
    logic [1:0] drop_s;

    // Overflow drops only. Inputs rejected because of a flush are not counted.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            drop_s[i] = in_valid[i] & full_s[i] & ~pop_s[i] & ~flush_s[i];
        end
    end

    // Saturating drop counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_1 <= 16'h0000;
            drop_cnt_2 <= 16'h0000;
        end else begin
            if (drop_s[0] && (drop_cnt_1 != 16'hFFFF)) begin
                drop_cnt_1 <= drop_cnt_1 + 16'h0001;
            end
            if (drop_s[1] && (drop_cnt_2 != 16'hFFFF)) begin
                drop_cnt_2 <= drop_cnt_2 + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_output_merger.sv
// Directed testbench for pipeline_output_merger (DATA_W=32, DEPTH=4).
// Each {out_valid, out_lane, out_data} check compares against a hand-computed tuple.
module tb_pipeline_output_merger;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data_1, in_data_2;
    logic [1:0]  in_valid;
    logic        flush_1, flush_2;
    logic [31:0] out_data;
    logic        out_lane, out_valid, out_ready;
    logic [1:0]  lane_full;
`ifdef MERGE_DROP_CNT_EN
    logic [15:0] drop_cnt_1, drop_cnt_2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_output_merger #(.DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_data_1(in_data_1), .in_data_2(in_data_2), .in_valid(in_valid),
        .flush_1(flush_1), .flush_2(flush_2),
        .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
        .out_ready(out_ready), .lane_full(lane_full)
`ifdef MERGE_DROP_CNT_EN
        , .drop_cnt_1(drop_cnt_1), .drop_cnt_2(drop_cnt_2)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        in_valid = 2'b00; in_data_1 = 32'h0; in_data_2 = 32'h0;
        flush_1 = 1'b0; flush_2 = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); out_ready = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle(); out_ready = 1'b1; reset = 1'b1;
        step();
        n_checks++;
        if ({out_valid, out_lane, out_data} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL reset_out: got v=%b l=%b d=%h want v=0 l=0 d=0", out_valid, out_lane, out_data);
        end
        n_checks++;
        if (lane_full !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b want 00", lane_full); end
`ifdef MERGE_DROP_CNT_EN
        n_checks++;
        if ({drop_cnt_1, drop_cnt_2} !== 32'h0) begin n_fail++; $display("FAIL reset_drop: got %h/%h want 0/0", drop_cnt_1, drop_cnt_2); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_single_lane();
        logic [31:0] exp_d;
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'hA0 + 32'(i);
            in_valid = 2'b01; in_data_1 = exp_d;
            step();
            n_checks++;
            if ({out_valid, out_lane, out_data} !== {1'b1, 1'b0, exp_d}) begin
                n_fail++; $display("FAIL single[%0d]: got v=%b l=%b d=%h want v=1 l=0 d=%h", i, out_valid, out_lane, out_data, exp_d);
            end
        end
        idle(); step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got v=%b want 0", out_valid); end
`ifdef MERGE_DROP_CNT_EN
        n_checks++;
        if (drop_cnt_1 !== 16'h0) begin n_fail++; $display("FAIL single_drop: got %h want 0", drop_cnt_1); end
`endif
    endtask

    task automatic test_fairness();
        logic [33:0] exp_t [4];
        exp_t[0] = {1'b1, 1'b0, 32'h11};
        exp_t[1] = {1'b1, 1'b1, 32'h22};
        exp_t[2] = {1'b1, 1'b0, 32'h33};
        exp_t[3] = {1'b1, 1'b1, 32'h44};
        do_reset(); out_ready = 1'b1;
        in_valid = 2'b11; in_data_1 = 32'h11; in_data_2 = 32'h22;
        step();
        in_data_1 = 32'h33; in_data_2 = 32'h44;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({out_valid, out_lane, out_data} !== exp_t[i]) begin
                n_fail++; $display("FAIL fair[%0d]: got v=%b l=%b d=%h want %h", i, out_valid, out_lane, out_data, exp_t[i]);
            end
            step(); idle();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fair_empty: got v=%b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        do_reset(); out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 2'b01; in_data_1 = 32'(i);
            step();
            n_checks++;
            if (lane_full !== ((i >= 4) ? 2'b01 : 2'b00)) begin
                n_fail++; $display("FAIL ovf_full[%0d]: got %b want %b", i, lane_full, (i >= 4) ? 2'b01 : 2'b00);
            end
        end
        idle();
`ifdef MERGE_DROP_CNT_EN
        n_checks++;
        if (drop_cnt_1 !== 16'h1) begin n_fail++; $display("FAIL ovf_drop: got %h want 0001", drop_cnt_1); end
`endif
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if ({out_valid, out_lane, out_data} !== {1'b1, 1'b0, 32'(i)}) begin
                n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b l=%b d=%h want v=1 l=0 d=%h", i, out_valid, out_lane, out_data, 32'(i));
            end
            step();
        end
        n_checks++;
        if ({out_valid, lane_full} !== 3'b000) begin n_fail++; $display("FAIL ovf_end: got v=%b full=%b want 0/00", out_valid, lane_full); end
    endtask

    task automatic test_full_pop_write();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h2; exp_d[1] = 32'h3; exp_d[2] = 32'h4; exp_d[3] = 32'h7;
        do_reset(); out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 2'b01; in_data_1 = 32'(i); step();
        end
        out_ready = 1'b1; in_valid = 2'b01; in_data_1 = 32'h7;
        step(); idle();
        n_checks++;
        if (lane_full !== 2'b01) begin n_fail++; $display("FAIL fpw_full: got %b want 01", lane_full); end
`ifdef MERGE_DROP_CNT_EN
        n_checks++;
        if (drop_cnt_1 !== 16'h0) begin n_fail++; $display("FAIL fpw_drop: got %h want 0", drop_cnt_1); end
`endif
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({out_valid, out_data} !== {1'b1, exp_d[i]}) begin
                n_fail++; $display("FAIL fpw_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_d[i]);
            end
            step();
        end
    endtask

    task automatic test_stability();
        do_reset(); out_ready = 1'b0;
        in_valid = 2'b10; in_data_2 = 32'h55; step();
        n_checks++;
        if ({out_valid, out_lane, out_data} !== {1'b1, 1'b1, 32'h55}) begin
            n_fail++; $display("FAIL stab_first: got v=%b l=%b d=%h want v=1 l=1 d=55", out_valid, out_lane, out_data);
        end
        idle(); in_valid = 2'b01; in_data_1 = 32'h66; step(); idle();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({out_valid, out_lane, out_data} !== {1'b1, 1'b1, 32'h55}) begin
                n_fail++; $display("FAIL stab_hold[%0d]: got v=%b l=%b d=%h want v=1 l=1 d=55", i, out_valid, out_lane, out_data);
            end
            step();
        end
        out_ready = 1'b1; step();
        n_checks++;
        if ({out_valid, out_lane, out_data} !== {1'b1, 1'b0, 32'h66}) begin
            n_fail++; $display("FAIL stab_next: got v=%b l=%b d=%h want v=1 l=0 d=66", out_valid, out_lane, out_data);
        end
        step();
    endtask

    task automatic test_flush();
        do_reset(); out_ready = 1'b0;
        in_valid = 2'b11; in_data_1 = 32'h10; in_data_2 = 32'h99; step();
        idle(); in_valid = 2'b01; in_data_1 = 32'h20; step();
        in_data_1 = 32'h30; step();
        n_checks++;
        if ({out_valid, out_lane, out_data} !== {1'b1, 1'b0, 32'h10}) begin
            n_fail++; $display("FAIL flush_pre: got v=%b l=%b d=%h want v=1 l=0 d=10", out_valid, out_lane, out_data);
        end
        in_valid = 2'b01; in_data_1 = 32'h40; flush_1 = 1'b1; step(); idle();
        n_checks++;
        if ({out_valid, out_lane, out_data} !== {1'b1, 1'b1, 32'h99}) begin
            n_fail++; $display("FAIL flush_post: got v=%b l=%b d=%h want v=1 l=1 d=99", out_valid, out_lane, out_data);
        end
        out_ready = 1'b1; step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got v=%b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset(); out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i < 2) ? 2'b11 : 2'b01;
            in_data_1 = 32'hC0 + 32'(i); in_data_2 = 32'hD0 + 32'(i); step();
        end
        idle();
        n_checks++;
        if ({out_valid, lane_full} !== 3'b101) begin n_fail++; $display("FAIL areset_pre: got v=%b full=%b want 1/01", out_valid, lane_full); end
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, lane_full} !== 3'b000) begin n_fail++; $display("FAIL areset_now: got v=%b full=%b want 0/00", out_valid, lane_full); end
        #1 reset = 1'b0;
        in_valid = 2'b11; in_data_1 = 32'hB1; in_data_2 = 32'hB2; step(); idle();
        n_checks++;
        if ({out_valid, out_lane, out_data} !== {1'b1, 1'b0, 32'hB1}) begin
            n_fail++; $display("FAIL areset_tie: got v=%b l=%b d=%h want v=1 l=0 d=b1", out_valid, out_lane, out_data);
        end
    endtask

    initial begin
        idle(); out_ready = 1'b0; reset = 1'b1;
        #2;
        test_reset();
        test_single_lane();
        test_fairness();
        test_overflow();
        test_full_pop_write();
        test_stability();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
